hs_ram_arbiter: RTL and testbench

HS_RAM_ARBITER -- requirements
Module: hs_ram_arbiter

---
 rtl/pengo_pkg.sv | 15 +
 rtl/pause_toggle_sync.sv | 27 ++
 rtl/hs_ram_arbiter.sv | 158 +++++++++++++++
 tb/tb_hs_ram_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pengo_pkg.sv
// Shared types and constants for the hiscore RAM arbiter.
package pengo_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STALL  = 2'd1,
    GRANT  = 2'd2,
    SETTLE = 2'd3
  } arb_state_t;

  // About 10 s of pause at 24 MHz before the video is dimmed
  localparam logic [31:0] DIM_CYCLES_DEFAULT = 32'h0E4E1C00;

endpackage

// File: rtl/pause_toggle_sync.sv
// Pause button front end: 2-flop synchroniser, rising-edge detect, toggle.
module pause_toggle_sync (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic user_pause,
  output logic pause_toggle
);

  logic [1:0] sync;
  logic       prev;

  // Synchronise the button and flip the toggle on each synchronised press
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sync         <= 2'b00;
      prev         <= 1'b0;
      pause_toggle <= 1'b0;
    end else begin
      sync <= {sync[0], user_pause};
      prev <= sync[1];
      if (sync[1] && !prev) begin
        pause_toggle <= ~pause_toggle;
      end
    end
  end

endmodule

// File: rtl/hs_ram_arbiter.sv
// Shares the CPU work RAM with the hiscore engine by stalling the core,
// and handles the user pause button with a long-pause video dim.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | CPU owns the RAM, no hiscore request pending
// STALL  | pause raised, waiting for cpu_halted or the ack timeout
// GRANT  | hiscore engine owns the RAM port
// SETTLE | grant released, pause held a few cycles before IDLE
module hs_ram_arbiter
  import pengo_pkg::*;
#(
  parameter logic [31:0] DIM_CYCLES    = DIM_CYCLES_DEFAULT,
  parameter logic [7:0]  ACK_TIMEOUT   = 8'd255,
  parameter logic [3:0]  SETTLE_CYCLES = 4'd2
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        user_pause,
  input  logic        cpu_halted,
  input  logic        hs_req,
  input  logic [11:0] hs_addr,
  input  logic [7:0]  hs_wdata,
  input  logic        hs_we,
  input  logic [11:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_we,
  output logic [11:0] ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        ram_we,
  output logic        hs_gnt,
  output logic        pause,
  output logic        dim,
  output logic        ack_err
);

  // The settle down-counter is loaded with N-1 and leaves on terminal count 0,
  // giving exactly N cycles in SETTLE (a zero setting behaves as one cycle).
  localparam logic [7:0] SETTLE_LOAD = (SETTLE_CYCLES == 4'd0) ? 8'd0
                                       : ({4'd0, SETTLE_CYCLES} - 8'd1);

  logic [1:0]  rst_sync;
  logic        rst_n;
  logic        pause_toggle;
  arb_state_t  state;
  arb_state_t  state_next;
  logic [7:0]  cnt;
  logic [7:0]  cnt_next;
  logic [7:0]  cnt_inc;
  logic        err_set;
  logic [31:0] dim_cnt;

  // Reset asserts immediately, releases after two clean clock edges
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  pause_toggle_sync u_pause_toggle_sync (
    .clk_sys      (clk_sys),
    .rst_n        (rst_n),
    .user_pause   (user_pause),
    .pause_toggle (pause_toggle)
  );

  assign cnt_inc = cnt + 8'd1;

  // FSM state, shared timeout/settle counter, sticky ack error and pause
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      ack_err <= 1'b0;
      pause   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (err_set) begin
        ack_err <= 1'b1;
      end
      pause <= pause_toggle | (state != IDLE);
    end
  end

  // Next-state logic; the counter times STALL upward and SETTLE downward
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        if (hs_req) begin
          state_next = STALL;
          cnt_next   = 8'd0;
        end
      end
      STALL: begin
        cnt_next = cnt_inc;
        if (!hs_req) begin
          state_next = SETTLE;
          cnt_next   = SETTLE_LOAD;
        end else if (cpu_halted) begin
          state_next = GRANT;
        end else if (cnt_inc == ACK_TIMEOUT) begin
          state_next = GRANT;
          err_set    = 1'b1;
        end
      end
      GRANT: begin
        if (!hs_req) begin
          state_next = SETTLE;
          cnt_next   = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        if (cnt == 8'd0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt - 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Dim timer: counts only during a user pause, saturates, clears when unpaused
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      dim_cnt <= 32'd0;
    end else if (!pause_toggle) begin
      dim_cnt <= 32'd0;
    end else if (dim_cnt != DIM_CYCLES) begin
      dim_cnt <= dim_cnt + 32'd1;
    end
  end

  assign dim = pause_toggle & (dim_cnt == DIM_CYCLES);

  // RAM port mux from the state register; raw reset_n blocks writes while
  // reset is held so a grant cut short by reset cannot corrupt RAM
  always_comb begin
    hs_gnt    = (state == GRANT);
    ram_addr  = cpu_addr;
    ram_wdata = cpu_wdata;
    ram_we    = cpu_we & ~pause & reset_n;
    if (state == GRANT) begin
      ram_addr  = hs_addr;
      ram_wdata = hs_wdata;
      ram_we    = hs_we & reset_n;
    end
  end

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// Directed bench for hs_ram_arbiter: mux vector table plus handshake sequences.
module tb_hs_ram_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        user_pause;
  logic        cpu_halted;
  logic        hs_req;
  logic [11:0] hs_addr;
  logic [7:0]  hs_wdata;
  logic        hs_we;
  logic [11:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic [11:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic        hs_gnt;
  logic        pause;
  logic        dim;
  logic        ack_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        grant;
    logic [11:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_we;
    logic [11:0] hs_addr;
    logic [7:0]  hs_wdata;
    logic        hs_we;
    logic [11:0] exp_addr;
    logic [7:0]  exp_wdata;
    logic        exp_we;
  } vec_t;

  vec_t vecs[8];

  hs_ram_arbiter #(
    .DIM_CYCLES    (32'd100),
    .ACK_TIMEOUT   (8'd8),
    .SETTLE_CYCLES (4'd2)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .user_pause (user_pause),
    .cpu_halted (cpu_halted),
    .hs_req     (hs_req),
    .hs_addr    (hs_addr),
    .hs_wdata   (hs_wdata),
    .hs_we      (hs_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_we     (cpu_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_we     (ram_we),
    .hs_gnt     (hs_gnt),
    .pause      (pause),
    .dim        (dim),
    .ack_err    (ack_err)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(3);
  endtask

  task automatic apply_vecs(input logic phase);
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].grant == phase) begin
        cpu_addr  = vecs[i].cpu_addr;
        cpu_wdata = vecs[i].cpu_wdata;
        cpu_we    = vecs[i].cpu_we;
        hs_addr   = vecs[i].hs_addr;
        hs_wdata  = vecs[i].hs_wdata;
        hs_we     = vecs[i].hs_we;
        #1;
        chk($sformatf("vec%0d_addr", i),  ram_addr,  vecs[i].exp_addr);
        chk($sformatf("vec%0d_wdata", i), ram_wdata, vecs[i].exp_wdata);
        chk($sformatf("vec%0d_we", i),    ram_we,    vecs[i].exp_we);
      end
    end
  endtask

  initial begin
    //          grant cpu_addr  cpu_wd cpu_we hs_addr  hs_wd  hs_we  exp_addr exp_wd exp_we
    vecs[0] = '{1'b0, 12'h123, 8'hA5, 1'b1, 12'hABC, 8'h5A, 1'b0, 12'h123, 8'hA5, 1'b1};
    vecs[1] = '{1'b0, 12'hFFF, 8'h00, 1'b0, 12'h000, 8'hFF, 1'b1, 12'hFFF, 8'h00, 1'b0};
    vecs[2] = '{1'b0, 12'h000, 8'hFF, 1'b1, 12'hFFF, 8'h00, 1'b1, 12'h000, 8'hFF, 1'b1};
    vecs[3] = '{1'b0, 12'h555, 8'h3C, 1'b0, 12'hAAA, 8'hC3, 1'b1, 12'h555, 8'h3C, 1'b0};
    vecs[4] = '{1'b1, 12'h123, 8'hA5, 1'b1, 12'hABC, 8'h5A, 1'b0, 12'hABC, 8'h5A, 1'b0};
    vecs[5] = '{1'b1, 12'hFFF, 8'h00, 1'b0, 12'h000, 8'hFF, 1'b1, 12'h000, 8'hFF, 1'b1};
    vecs[6] = '{1'b1, 12'h000, 8'hFF, 1'b1, 12'h800, 8'h81, 1'b1, 12'h800, 8'h81, 1'b1};
    vecs[7] = '{1'b1, 12'h555, 8'h3C, 1'b1, 12'h7FE, 8'h7E, 1'b0, 12'h7FE, 8'h7E, 1'b0};

    reset_n    = 1'b1;
    user_pause = 1'b0;
    cpu_halted = 1'b0;
    hs_req     = 1'b0;
    hs_addr    = 12'h000;
    hs_wdata   = 8'h00;
    hs_we      = 1'b0;
    cpu_addr   = 12'h111;
    cpu_wdata  = 8'h22;
    cpu_we     = 1'b1;

    // reset values, before any clock edge
    #1 reset_n = 1'b0;
    #2;
    chk("rst_hs_gnt", hs_gnt, 1'b0);
    chk("rst_pause", pause, 1'b0);
    chk("rst_dim", dim, 1'b0);
    chk("rst_ack_err", ack_err, 1'b0);
    chk("rst_ram_we", ram_we, 1'b0);
    chk("rst_ram_addr", ram_addr, 12'h111);
    tick(2);
    reset_n = 1'b1;
    tick(3);
    chk("idle_ram_we", ram_we, 1'b1);

    // RAM mux while idle
    apply_vecs(1'b0);

    // grant handshake
    cpu_we  = 1'b0;
    hs_req  = 1'b1;
    hs_addr = 12'h2A5;
    hs_we   = 1'b0;
    tick(2);
    chk("hs_pause", pause, 1'b1);
    tick(1);
    chk("hs_gnt_before_halt", hs_gnt, 1'b0);
    cpu_halted = 1'b1;
    tick(1);
    chk("hs_gnt_after_halt", hs_gnt, 1'b1);
    chk("hs_ram_addr", ram_addr, 12'h2A5);

    // RAM mux while granted
    apply_vecs(1'b1);

    // release and immediate re-request
    hs_req = 1'b0;
    tick(1);
    chk("rel_gnt_e0", hs_gnt, 1'b0);
    chk("rel_pause_e0", pause, 1'b1);
    hs_req = 1'b1;
    tick(1);
    chk("rel_gnt_e1", hs_gnt, 1'b0);
    chk("rel_pause_e1", pause, 1'b1);
    tick(1);
    chk("rel_gnt_e2", hs_gnt, 1'b0);
    chk("rel_pause_e2", pause, 1'b1);
    tick(1);
    chk("rel_gnt_e3", hs_gnt, 1'b0);
    chk("rel_pause_idle", pause, 1'b0);
    tick(1);
    chk("rel_regrant", hs_gnt, 1'b1);

    // reset in the middle of a grant with a hiscore write in flight
    hs_we = 1'b1;
    cpu_addr = 12'h3C3;
    #1;
    chk("mid_grant_we", ram_we, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_gnt", hs_gnt, 1'b0);
    chk("mid_rst_we", ram_we, 1'b0);
    chk("mid_rst_addr", ram_addr, 12'h3C3);
    hs_req = 1'b0;
    cpu_halted = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(3);
    chk("post_rst_pause", pause, 1'b0);
    chk("post_rst_gnt", hs_gnt, 1'b0);
    chk("post_rst_ack_err", ack_err, 1'b0);

    // acknowledge timeout
    hs_req = 1'b1;
    tick(8);
    chk("to_gnt_before", hs_gnt, 1'b0);
    chk("to_err_before", ack_err, 1'b0);
    tick(1);
    chk("to_gnt", hs_gnt, 1'b1);
    chk("to_err", ack_err, 1'b1);
    hs_req = 1'b0;
    tick(5);
    chk("to_err_sticky", ack_err, 1'b1);
    chk("to_gnt_released", hs_gnt, 1'b0);
    do_reset();
    chk("to_err_cleared", ack_err, 1'b0);

    // user pause, cpu write blocking and dim
    cpu_we = 1'b0;
    user_pause = 1'b1;
    tick(3);
    chk("up_pause_early", pause, 1'b0);
    tick(1);
    chk("up_pause", pause, 1'b1);
    user_pause = 1'b0;
    cpu_we = 1'b1;
    #1;
    chk("up_cpu_we_blocked", ram_we, 1'b0);
    tick(98);
    chk("dim_early", dim, 1'b0);
    tick(1);
    chk("dim_on", dim, 1'b1);

    // hiscore request during user pause still needs the halt handshake
    hs_req = 1'b1;
    tick(2);
    chk("up_hs_no_shortcut", hs_gnt, 1'b0);
    cpu_halted = 1'b1;
    tick(1);
    chk("up_hs_gnt", hs_gnt, 1'b1);
    hs_req = 1'b0;
    cpu_halted = 1'b0;
    tick(4);
    chk("up_pause_kept", pause, 1'b1);
    chk("up_dim_kept", dim, 1'b1);

    // second press un-pauses and undims
    user_pause = 1'b1;
    tick(2);
    user_pause = 1'b0;
    tick(2);
    chk("unpause_dim", dim, 1'b0);
    chk("unpause_pause", pause, 1'b0);
    chk("unpause_cpu_we", ram_we, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
